instability_sweep_ctrl: RTL and testbench

Sequencer that locates the bias-current instability point of the resonator front end. It steps the reference current (i_ref_setup) downward from full scale in a coarse pass, then a fine pass. At each point it waits a settle interval, requests one Q measurement through a req/valid handshake, and flags instability when Q jumps by more than DELTA. It reports the lowest stable i_ref found and sits between the top-level control FSM, the bias DAC and the Q-measurement unit.

---
 rtl/instability_sweep_ctrl_if.sv | 24 ++
 rtl/instability_sweep_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_instability_sweep_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instability_sweep_ctrl_if.sv
// rtl/instability_sweep_ctrl_if.sv - control, bias DAC and Q-measurement signals of the sweep sequencer
interface instability_sweep_ctrl_if #(
    parameter int WIDTH = 10
);
    logic             start;
    logic [WIDTH-1:0] q_measured;
    logic             q_valid;
    logic             meas_req;
    logic [WIDTH-1:0] i_ref_setup;
    logic             busy;
    logic             done;
    logic             found;
    logic             timeout_err;

    modport master (
        input  start, q_measured, q_valid,
        output meas_req, i_ref_setup, busy, done, found, timeout_err
    );

    modport slave (
        output start, q_measured, q_valid,
        input  meas_req, i_ref_setup, busy, done, found, timeout_err
    );
endinterface

// File: rtl/instability_sweep_ctrl.sv
// rtl/instability_sweep_ctrl.sv - coarse/fine i_ref sweep that locates the Q instability point
module instability_sweep_ctrl #(
    parameter int WIDTH         = 10,
    parameter int DELTA         = 300,
    parameter int COARSE_STEP   = 50,
    parameter int FINE_STEP     = 5,
    parameter int SETTLE_CYCLES = 16,
    parameter int TIMEOUT       = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    instability_sweep_ctrl_if.master bus
);
    localparam int RATIO = COARSE_STEP / FINE_STEP;
    localparam int SW    = $clog2(SETTLE_CYCLES) + 1;
    localparam int TW    = $clog2(TIMEOUT) + 1;
    localparam int FW    = $clog2(RATIO) + 1;

    localparam logic [WIDTH-1:0] I_REF_MAX = '1;
    localparam logic [WIDTH-1:0] C_STEP    = WIDTH'(COARSE_STEP);
    localparam logic [WIDTH-1:0] F_STEP    = WIDTH'(FINE_STEP);
    localparam logic [WIDTH-1:0] DELTA_W   = WIDTH'(DELTA);

    typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, EVAL, DONE} state_t;
    typedef enum logic {COARSE, FINE} phase_t;

    state_t           state, state_n;
    phase_t           phase, phase_n;
    logic             baseline, baseline_n;
    logic [SW-1:0]    settle_cnt, settle_cnt_n;
    logic [TW-1:0]    tmo_cnt, tmo_cnt_n;
    logic [FW-1:0]    fine_cnt, fine_cnt_n;
    logic [WIDTH-1:0] q_new, q_new_n;
    logic [WIDTH-1:0] q_prev, q_prev_n;
    logic [WIDTH-1:0] last_stable, last_stable_n;
    logic [WIDTH-1:0] i_ref, i_ref_n;
    logic             meas_req, meas_req_n;
    logic             busy, busy_n;
    logic             done, done_n;
    logic             found, found_n;
    logic             tmo_err, tmo_err_n;

    logic [WIDTH-1:0] step;
    logic             jump;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            phase       <= COARSE;
            baseline    <= 1'b0;
            settle_cnt  <= '0;
            tmo_cnt     <= '0;
            fine_cnt    <= '0;
            q_new       <= '0;
            q_prev      <= '0;
            last_stable <= '0;
            i_ref       <= I_REF_MAX;
            meas_req    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            tmo_err     <= 1'b0;
        end else begin
            state       <= state_n;
            phase       <= phase_n;
            baseline    <= baseline_n;
            settle_cnt  <= settle_cnt_n;
            tmo_cnt     <= tmo_cnt_n;
            fine_cnt    <= fine_cnt_n;
            q_new       <= q_new_n;
            q_prev      <= q_prev_n;
            last_stable <= last_stable_n;
            i_ref       <= i_ref_n;
            meas_req    <= meas_req_n;
            busy        <= busy_n;
            done        <= done_n;
            found       <= found_n;
            tmo_err     <= tmo_err_n;
        end
    end

    always_comb begin
        state_n       = state;
        phase_n       = phase;
        baseline_n    = baseline;
        settle_cnt_n  = settle_cnt;
        tmo_cnt_n     = tmo_cnt;
        fine_cnt_n    = fine_cnt;
        q_new_n       = q_new;
        q_prev_n      = q_prev;
        last_stable_n = last_stable;
        i_ref_n       = i_ref;
        found_n       = found;
        tmo_err_n     = tmo_err;

        step = (phase == COARSE) ? C_STEP : F_STEP;
        // Unsigned guard first so a large Q drop cannot wrap into a false jump.
        jump = (q_new > q_prev) && ((q_new - q_prev) > DELTA_W);

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n      = SETTLE;
                    i_ref_n      = I_REF_MAX;
                    phase_n      = COARSE;
                    baseline_n   = 1'b1;
                    found_n      = 1'b0;
                    tmo_err_n    = 1'b0;
                    settle_cnt_n = '0;
                end
            end
            SETTLE: begin
                if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                    state_n   = MEASURE;
                    tmo_cnt_n = '0;
                end else begin
                    settle_cnt_n = settle_cnt + SW'(1);
                end
            end
            MEASURE: begin
                if (bus.q_valid) begin
                    q_new_n = bus.q_measured;
                    state_n = EVAL;
                end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    state_n   = DONE;
                    tmo_err_n = 1'b1;
                    found_n   = 1'b0;
                    i_ref_n   = I_REF_MAX;
                end else begin
                    tmo_cnt_n = tmo_cnt + TW'(1);
                end
            end
            EVAL: begin
                if (!baseline && jump) begin
                    if (phase == COARSE) begin
                        // Back up to the last stable coarse point and refine below it.
                        i_ref_n      = last_stable;
                        phase_n      = FINE;
                        baseline_n   = 1'b1;
                        fine_cnt_n   = '0;
                        settle_cnt_n = '0;
                        state_n      = SETTLE;
                    end else begin
                        state_n = DONE;
                        found_n = 1'b1;
                        i_ref_n = last_stable;
                    end
                end else begin
                    baseline_n    = 1'b0;
                    q_prev_n      = q_new;
                    last_stable_n = i_ref;
                    if ((phase == FINE) && ((fine_cnt == FW'(RATIO - 1)) || (i_ref < step))) begin
                        // Fine pass spanned the whole coarse interval: current point is the answer.
                        state_n = DONE;
                        found_n = 1'b1;
                        i_ref_n = i_ref;
                    end else if (i_ref < step) begin
                        state_n = DONE;
                        found_n = 1'b0;
                        i_ref_n = I_REF_MAX;
                    end else begin
                        i_ref_n      = i_ref - step;
                        fine_cnt_n   = (phase == FINE) ? fine_cnt + FW'(1) : fine_cnt;
                        settle_cnt_n = '0;
                        state_n      = SETTLE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        meas_req_n = (state_n == MEASURE);
        busy_n     = (state_n != IDLE);
        done_n     = (state_n == DONE);
    end

    assign bus.meas_req    = meas_req;
    assign bus.i_ref_setup = i_ref;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.found       = found;
    assign bus.timeout_err = tmo_err;
endmodule

// File: tb/tb_instability_sweep_ctrl.sv
// tb/tb_instability_sweep_ctrl.sv - scoreboard bench for instability_sweep_ctrl with a bias/Q plant model
module tb_instability_sweep_ctrl;
    localparam int W = 10;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instability_sweep_ctrl_if #(.WIDTH(W)) sif ();

    instability_sweep_ctrl #(
        .WIDTH(W), .DELTA(300), .COARSE_STEP(50), .FINE_STEP(5),
        .SETTLE_CYCLES(4), .TIMEOUT(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(sif)
    );

    typedef struct {
        int found;
        int tmo;
        int iref;
        int points;
        int req_len;
    } exp_t;

    exp_t exp_q[$];
    int   pt_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Plant modes: 0 step at 612, 1 flat, 2 silent, 3 drop after first point,
    // 4 gentle slope below 623, 5 rippled step at 612
    int plant_mode  = 1;
    int plant_delay = 0;
    int wait_cnt    = 0;

    function automatic logic [W-1:0] qfun(input int mode, input int i);
        int q;
        case (mode)
            0:       q = (i >= 612) ? 100 : 600;
            3:       q = (i == 1023) ? 900 : 100;
            4:       q = (i >= 623) ? 100 : 100 + (623 - i) * 10;
            5:       q = (i >= 612) ? 100 + (i % 7) * 10 : 600;
            default: q = 100;
        endcase
        if (q > 1023) q = 1023;
        return W'(q);
    endfunction

    initial begin
        sif.q_valid    = 1'b0;
        sif.q_measured = '0;
        forever begin
            @(negedge clk);
            if (sif.meas_req) begin
                wait_cnt++;
                if (plant_mode != 2 && wait_cnt > plant_delay) begin
                    sif.q_valid    = 1'b1;
                    sif.q_measured = qfun(plant_mode, int'(sif.i_ref_setup));
                end
            end else begin
                wait_cnt    = 0;
                sif.q_valid = 1'b0;
            end
        end
    end

    int         points    = 0;
    int         req_len   = 0;
    int         moves     = 0;
    int         done_seen = 0;
    logic       prev_req  = 1'b0;
    logic [W-1:0] prev_iref = '1;

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sif.meas_req && !prev_req) begin
                points++;
                req_len = 0;
                if (pt_q.size() > 0) check_val("point_i_ref", sif.i_ref_setup, pt_q.pop_front());
            end
            if (sif.meas_req) req_len++;
            if (sif.meas_req && prev_req && sif.i_ref_setup != prev_iref) moves++;
            if (sif.done) begin
                done_seen++;
                if (exp_q.size() == 0) begin
                    check_val("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("found", sif.found, e.found);
                    check_val("timeout_err", sif.timeout_err, e.tmo);
                    check_val("i_ref_result", sif.i_ref_setup, e.iref);
                    check_val("points_visited", points, e.points);
                    if (e.req_len > 0) check_val("meas_req_len", req_len, e.req_len);
                    check_val("points_unvisited", pt_q.size(), 0);
                    check_val("i_ref_moved_in_measure", moves, 0);
                end
            end
            prev_req  = sif.meas_req;
            prev_iref = sif.i_ref_setup;
        end
    end

    task automatic push_pts(input int from, input int to, input int step);
        for (int i = from; i >= to; i -= step) pt_q.push_back(i);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
    endtask

    task automatic do_sweep(input int mode, input int dly, input int poke_at,
                            input int f, input int t, input int ir, input int np, input int rl);
        exp_t e;
        int   d0;
        int   cyc;
        bit   poked;
        e.found = f; e.tmo = t; e.iref = ir; e.points = np; e.req_len = rl;
        exp_q.push_back(e);
        plant_mode  = mode;
        plant_delay = dly;
        points      = 0;
        moves       = 0;
        poked       = 1'b0;
        d0          = done_seen;
        pulse_start();
        cyc = 0;
        while (done_seen == d0 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (poke_at > 0 && !poked && points >= poke_at) begin
                sif.start = 1'b1;
                @(negedge clk);
                sif.start = 1'b0;
                poked = 1'b1;
            end
        end
        check_val("done_count", done_seen - d0, 1);
        if (done_seen == d0) begin
            exp_q.delete();
            pt_q.delete();
        end
        @(posedge clk);
        #1;
        check_val("busy_after_done", sif.busy, 0);
        check_val("done_one_cycle", sif.done, 0);
        repeat (5) @(posedge clk);
        #1;
        check_val("found_held", sif.found, f);
        check_val("timeout_err_held", sif.timeout_err, t);
        check_val("i_ref_held", sif.i_ref_setup, ir);
    endtask

    initial begin
        int d0;
        int cyc;
        rst       = 1'b1;
        sif.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", sif.busy, 0);
        check_val("rst_meas_req", sif.meas_req, 0);
        check_val("rst_done", sif.done, 0);
        check_val("rst_found", sif.found, 0);
        check_val("rst_timeout_err", sif.timeout_err, 0);
        check_val("rst_i_ref", sif.i_ref_setup, 1023);

        @(negedge clk);
        sif.start = 1'b1;
        @(negedge clk);
        sif.start = 1'b0;
        rst       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("start_with_rst_ignored", sif.busy, 0);

        push_pts(1023, 573, 50);
        push_pts(623, 608, 5);
        do_sweep(0, 0, 0, 1, 0, 613, 14, 0);

        push_pts(1023, 23, 50);
        do_sweep(1, 0, 0, 0, 0, 1023, 21, 0);

        pt_q.push_back(1023);
        do_sweep(2, 0, 0, 0, 1, 1023, 1, 64);

        push_pts(1023, 23, 50);
        do_sweep(3, 0, 0, 0, 0, 1023, 21, 0);

        push_pts(1023, 573, 50);
        push_pts(623, 608, 5);
        do_sweep(5, 2, 5, 1, 0, 613, 14, 0);

        push_pts(1023, 573, 50);
        push_pts(623, 578, 5);
        do_sweep(4, 0, 0, 1, 0, 578, 20, 0);

        plant_mode  = 5;
        plant_delay = 2;
        points      = 0;
        d0          = done_seen;
        pulse_start();
        cyc = 0;
        while (!(points >= 3 && sif.meas_req) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check_val("reached_third_measure", (points >= 3 && sif.meas_req), 1);
        check_val("i_ref_before_rst", sif.i_ref_setup, 923);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("abort_meas_req", sif.meas_req, 0);
        check_val("abort_busy", sif.busy, 0);
        check_val("abort_i_ref", sif.i_ref_setup, 1023);
        check_val("abort_found", sif.found, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check_val("abort_no_done", done_seen - d0, 0);
        check_val("abort_idle", sif.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
